// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the bus width, the ownership state encoding and a small alignment helper.
package dmem_arbiter_pkg;

    localparam int DMEM_WORD = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // A doubleword access is aligned only when the low three byte-address bits are zero.
    function automatic logic is_misaligned(input logic [2:0] low_bits);
        return low_bits != 3'b000;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bus between the two requesters and the data-memory arbiter.
// The master side drives requests; the slave side returns grants and read responses.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int WORD = DMEM_WORD
) ();

    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [1:0]      req_lock;
    logic [WORD-1:0] req_addr0;
    logic [WORD-1:0] req_addr1;
    logic [WORD-1:0] req_wdata0;
    logic [WORD-1:0] req_wdata1;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [WORD-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr.
// next_ptr points away from whoever was granted so the other side wins the next tie.
module dmem_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
        next_ptr = ptr;
        if (grant[0]) begin
            next_ptr = 1'b1;
        end else if (grant[1]) begin
            next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory: round-robin grants,
// bus lock for read-modify-write with a timeout watchdog, registered read responses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WORD     = DMEM_WORD,
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    output logic            err_misalign,
    output logic            err_lock_to
);

    arb_state_t      state;
    logic            rr_ptr;
    logic            arb_next_ptr;
    logic            sel;
    logic            own_idx;
    logic            timeout;
    logic [1:0]      arb_grant;
    logic [1:0]      grant;
    logic [1:0]      rd_grant;
    logic [1:0]      block;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]      rsp_valid_q;
    logic [WORD-1:0] rsp_data_q;

    dmem_arbiter_rr_arb2 u_rr (
        .valid    (bus.req_valid),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .next_ptr (arb_next_ptr)
    );

    // Grants are gated by rst so every output reads zero while reset is held.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (state)
                IDLE:    grant = arb_grant;
                OWN0:    grant = {1'b0, bus.req_valid[0]};
                OWN1:    grant = {bus.req_valid[1], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel      = grant[1];
    assign own_idx  = (state == OWN1);
    assign rd_grant = grant & ~bus.req_we;
    assign timeout  = (state != IDLE) && bus.req_lock[own_idx] &&
                      (lock_cnt == CNT_W'(MAX_LOCK));

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant != 2'b00) begin
            MemWrite  = bus.req_we[sel];
            MemRead   = ~bus.req_we[sel];
            mem_addr  = sel ? bus.req_addr1 : bus.req_addr0;
            mem_wdata = sel ? bus.req_wdata1 : bus.req_wdata0;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            lock_cnt     <= '0;
            block        <= 2'b00;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            err_misalign <= 1'b0;
            err_lock_to  <= 1'b0;
        end else begin
            rsp_valid_q <= rd_grant;
            if (rd_grant != 2'b00) begin
                rsp_data_q <= mem_rdata;
            end
            if (grant != 2'b00 && is_misaligned(mem_addr[2:0])) begin
                err_misalign <= 1'b1;
            end
            // A timed-out owner may relock only after it has let go of req_lock once.
            block <= block & bus.req_lock;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        rr_ptr <= arb_next_ptr;
                        if (bus.req_lock[sel] && !block[sel]) begin
                            state    <= sel ? OWN1 : OWN0;
                            lock_cnt <= CNT_W'(1);
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (grant != 2'b00) begin
                        rr_ptr <= ~own_idx;
                    end
                    if (!bus.req_lock[own_idx]) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (timeout) begin
                        state          <= IDLE;
                        lock_cnt       <= '0;
                        err_lock_to    <= 1'b1;
                        rr_ptr         <= ~own_idx;
                        block[own_idx] <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small memory model and a response scoreboard.
// Grants are checked in-cycle; read responses are queued and matched by a separate monitor.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct {
        logic [1:0]  who;
        logic [63:0] data;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead, MemWrite, err_misalign, err_lock_to;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, memIdx;
    logic [63:0] mem [0:15] = '{64'h0, 64'h0, 64'hDEAD, 64'hBEEF, 64'h1234, 64'h5555, 64'h6666, 64'h0,
                                64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    rsp_exp_t    sb[$];
    rsp_exp_t    monE;
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter_if #(.WORD(64)) bus ();

    dmem_arbiter #(.WORD(64), .MAX_LOCK(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .err_misalign (err_misalign),
        .err_lock_to  (err_lock_to)
    );

    always #5 clk = ~clk;

    assign memIdx    = mem_addr >> 3;
    assign mem_rdata = (memIdx < 64'd16) ? mem[memIdx[3:0]] : 64'h0;

    always @(posedge clk) begin
        if (MemWrite && memIdx < 64'd16) mem[memIdx[3:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Every response the DUT presents must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst !== 1'b1 && bus.rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                checkOutput("stray_rsp_valid", 64'(bus.rsp_valid), 64'h0);
            end else begin
                monE = sb.pop_front();
                checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(monE.who));
                checkOutput("rsp_data", bus.rsp_data, monE.data);
            end
        end
    end

    task automatic setInputs(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                             input logic [63:0] a0, input logic [63:0] a1,
                             input logic [63:0] d0, input logic [63:0] d1);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_lock   = lk;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_wdata0 = d0;
        bus.req_wdata1 = d1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                                 input logic [63:0] a0, input logic [63:0] a1,
                                 input logic [63:0] d0, input logic [63:0] d1);
        @(posedge clk);
        #1;
        setInputs(v, we, lk, a0, a1, d0, d1);
    endtask

    // g is the hand-computed grant; for a granted read, rd is the data expected next cycle.
    task automatic expectGrant(input string tag, input logic [1:0] g, input logic [63:0] rd,
                               input bit keep);
        logic s;
        logic w;
        @(negedge clk);
        checkOutput({tag, "/ready"}, 64'(bus.req_ready), 64'(g));
        if (g == 2'b00) begin
            checkOutput({tag, "/ctl"}, 64'({MemRead, MemWrite}), 64'h0);
            checkOutput({tag, "/addr"}, mem_addr, 64'h0);
        end else begin
            s = g[1];
            w = bus.req_we[s];
            checkOutput({tag, "/ctl"}, 64'({MemRead, MemWrite}), 64'({~w, w}));
            checkOutput({tag, "/addr"}, mem_addr, s ? bus.req_addr1 : bus.req_addr0);
            if (w) checkOutput({tag, "/wdata"}, mem_wdata, s ? bus.req_wdata1 : bus.req_wdata0);
            else if (keep) sb.push_back('{who: g, data: rd});
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        setInputs(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] relockV  [4] = '{2'b01, 2'b01, 2'b11, 2'b01};
        logic [1:0] relockLk [4] = '{2'b00, 2'b01, 2'b01, 2'b00};

        setInputs(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        #3;
        checkOutput("reset/ready", 64'(bus.req_ready), 64'h0);
        checkOutput("reset/rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("reset/rsp_data", bus.rsp_data, 64'h0);
        checkOutput("reset/ctl", 64'({MemRead, MemWrite}), 64'h0);
        checkOutput("reset/errs", 64'({err_misalign, err_lock_to}), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single read");
        applyStimulus(2'b01, 2'b00, 2'b00, 64'h10, 64'h0, 64'h0, 64'h0);
        expectGrant("single", 2'b01, 64'hDEAD, 1'b1);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        expectGrant("single_idle", 2'b00, 64'h0, 1'b0);

        $display("[TB] contention");
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b00, 2'b00, 64'h18, 64'h20, 64'h0, 64'h0);
            if (i % 2 == 1) expectGrant("contend", 2'b10, 64'h1234, 1'b1);
            else            expectGrant("contend", 2'b01, 64'hBEEF, 1'b1);
        end

        $display("[TB] locked read-modify-write");
        applyStimulus(2'b01, 2'b00, 2'b00, 64'h30, 64'h0, 64'h0, 64'h0);
        expectGrant("rmw_setup", 2'b01, 64'h6666, 1'b1);
        applyStimulus(2'b11, 2'b00, 2'b10, 64'h10, 64'h20, 64'h0, 64'h0);
        expectGrant("rmw_read", 2'b10, 64'h1234, 1'b1);
        applyStimulus(2'b11, 2'b10, 2'b00, 64'h10, 64'h20, 64'h0, 64'hABCD);
        expectGrant("rmw_write", 2'b10, 64'h0, 1'b0);
        applyStimulus(2'b11, 2'b00, 2'b00, 64'h20, 64'h10, 64'h0, 64'h0);
        expectGrant("rmw_after", 2'b01, 64'hABCD, 1'b1);

        $display("[TB] lock timeout");
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i == 0) ? 2'b01 : 2'b11, 2'b00, 2'b01, 64'h10, 64'h28, 64'h0, 64'h0);
            if (i == 17 || i == 19) expectGrant("timeout", 2'b10, 64'h5555, 1'b1);
            else                    expectGrant("timeout", 2'b01, 64'hDEAD, 1'b1);
            if (i == 16) checkOutput("lock_to_before", 64'(err_lock_to), 64'h0);
            if (i == 17) checkOutput("lock_to_set", 64'(err_lock_to), 64'h1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(relockV[i], 2'b00, relockLk[i], 64'h10, 64'h28, 64'h0, 64'h0);
            expectGrant("relock", 2'b01, 64'hDEAD, 1'b1);
        end

        $display("[TB] misaligned write");
        applyStimulus(2'b01, 2'b01, 2'b00, 64'h0B, 64'h0, 64'h55, 64'h0);
        expectGrant("misalign", 2'b01, 64'h0, 1'b0);
        checkOutput("misalign_before", 64'(err_misalign), 64'h0);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        expectGrant("misalign_idle", 2'b00, 64'h0, 1'b0);
        checkOutput("misalign_set", 64'(err_misalign), 64'h1);
        applyStimulus(2'b01, 2'b00, 2'b00, 64'h08, 64'h0, 64'h0, 64'h0);
        expectGrant("misalign_readback", 2'b01, 64'h55, 1'b1);
        checkOutput("misalign_sticky", 64'(err_misalign), 64'h1);
        checkOutput("lock_to_sticky", 64'(err_lock_to), 64'h1);

        $display("[TB] reset during lock");
        applyStimulus(2'b10, 2'b00, 2'b10, 64'h0, 64'h20, 64'h0, 64'h0);
        expectGrant("own1", 2'b10, 64'hABCD, 1'b1);
        applyStimulus(2'b11, 2'b00, 2'b10, 64'h10, 64'h28, 64'h0, 64'h0);
        expectGrant("own1_hold", 2'b10, 64'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset/ready", 64'(bus.req_ready), 64'h0);
        checkOutput("midreset/rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("midreset/rsp_data", bus.rsp_data, 64'h0);
        checkOutput("midreset/ctl", 64'({MemRead, MemWrite}), 64'h0);
        checkOutput("midreset/addr", mem_addr, 64'h0);
        checkOutput("midreset/errs", 64'({err_misalign, err_lock_to}), 64'h0);
        setInputs(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 64'h10, 64'h28, 64'h0, 64'h0);
        expectGrant("post_reset", 2'b01, 64'hDEAD, 1'b1);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        expectGrant("final_idle", 2'b00, 64'h0, 1'b0);
        @(negedge clk);
        checkOutput("responses_outstanding", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
